// File: rtl/chimp_seq_ctrl.sv
// chimp_seq_ctrl -- sequence controller for the "chimp test" memory game.
// Walks a game through start, board load, number picking, level-up,
// strikes and game over; the board datapath only sees load/show/reset
// strobes and the number it should accept next.
module chimp_seq_ctrl #(
   parameter int MAX_NUMS    = 31,
   parameter int START_LEVEL = 4,
   parameter int LIVES       = 3,
   localparam int NW = $clog2(MAX_NUMS+1),
   localparam int SW = $clog2(LIVES+1)
) (
   input  logic          clk,
   input  logic          iReset,
   input  logic          iSpace,
   input  logic          iDoneLoad,
   input  logic          iChoseCorrectNum,
   input  logic          iChoseWrongNum,
   output logic [NW-1:0] oNumToChoose,
   output logic [NW-1:0] oLevel,
   output logic [SW-1:0] oStrikes,
   output logic [NW-1:0] oBest,
   output logic          oLoadEnable,
   output logic          oShowEnable,
   output logic          oResetBoard,
   output logic          oGameOver,
   output logic          oWin,
   output logic [2:0]    oState
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      LOAD   = 3'd2,
      CHOOSE = 3'd3,
      NEXT   = 3'd4,
      STRIKE = 3'd5,
      OVER   = 3'd6
   } state_t;

   localparam logic [NW-1:0] LVL_START = NW'(START_LEVEL);
   localparam logic [NW-1:0] LVL_MAX   = NW'(MAX_NUMS);
   localparam logic [SW-1:0] LIVES_W   = SW'(LIVES);

   state_t        state, state_n;
   logic [NW-1:0] level, level_n;
   logic [NW-1:0] num, num_n;
   logic [SW-1:0] strikes, strikes_n;
   logic [NW-1:0] best, best_n;
   logic          win, win_n;
   logic          load_en;
   logic          game_over;

   logic [SW-1:0] strikes_inc;
   logic [NW-1:0] best_max;

   assign strikes_inc = strikes + SW'(1);
   assign best_max    = (level > best) ? level : best;

   // State register plus all game counters; reset wins over everything.
   always_ff @(posedge clk) begin
      if (iReset) begin
         state     <= IDLE;
         level     <= LVL_START;
         num       <= '0;
         strikes   <= '0;
         best      <= '0;
         win       <= 1'b0;
         load_en   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         level     <= level_n;
         num       <= num_n;
         strikes   <= strikes_n;
         best      <= best_n;
         win       <= win_n;
         // Flag outputs are registered copies of the upcoming state so they
         // change together with oState and come straight off flops.
         load_en   <= (state_n == LOAD);
         game_over <= (state_n == OVER);
      end
   end

   // Next-state and next-counter logic; everything holds unless changed.
   always_comb begin
      state_n   = state;
      level_n   = level;
      num_n     = num;
      strikes_n = strikes;
      best_n    = best;
      win_n     = win;
      unique case (state)
         IDLE: begin
            level_n   = LVL_START;
            strikes_n = '0;
            num_n     = '0;
            win_n     = 1'b0;
            if (iSpace) state_n = ARM;
         end
         ARM: begin
            // Hold here until the start key is released so one press
            // does not also count as a restart later.
            if (!iSpace) state_n = LOAD;
         end
         LOAD: begin
            if (iDoneLoad) begin
               num_n   = NW'(1);
               state_n = CHOOSE;
            end
         end
         CHOOSE: begin
            // A wrong click beats a simultaneous correct one; num is left
            // alone so the strike path does not disturb it.
            if (iChoseWrongNum) begin
               state_n = STRIKE;
            end else if (iChoseCorrectNum) begin
               if (num < level) num_n   = num + NW'(1);
               else             state_n = NEXT;
            end
         end
         NEXT: begin
            best_n = best_max;
            if (level == LVL_MAX) begin
               win_n   = 1'b1;
               state_n = OVER;
            end else begin
               level_n = level + NW'(1);
               state_n = LOAD;
            end
         end
         STRIKE: begin
            strikes_n = strikes_inc;
            if (strikes_inc == LIVES_W) begin
               win_n   = 1'b0;
               state_n = OVER;
            end else begin
               state_n = LOAD;
            end
         end
         OVER: begin
            // Best score survives a new game; only reset clears it.
            if (iSpace) begin
               level_n   = LVL_START;
               strikes_n = '0;
               win_n     = 1'b0;
               state_n   = ARM;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Output decode: only the three strobes below are combinational.
   assign oNumToChoose = (state == CHOOSE) ? num : '0;
   assign oShowEnable  = (state == LOAD) || ((state == CHOOSE) && (num == NW'(1)));
   assign oResetBoard  = iReset || (state == IDLE) || (state == ARM) ||
                         (state == STRIKE) || (state == NEXT);

   assign oLevel      = level;
   assign oStrikes    = strikes;
   assign oBest       = best;
   assign oLoadEnable = load_en;
   assign oGameOver   = game_over;
   assign oWin        = win;
   assign oState      = state;

endmodule

// File: doc/chimp_seq_ctrl.md
CHIMP_SEQ_CTRL -- requirements
Module: chimp_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_NUMS, default 31, meaning the highest level (and highest number on the board); legal range 2..63.
REQ-002 SHALL have parameter START_LEVEL, default 4, meaning the level of a new game; legal range 1..MAX_NUMS.
REQ-003 SHALL have parameter LIVES, default 3, meaning wrong picks allowed before game over; legal range 1..7.
REQ-004 SHALL derive localparam NW = $clog2(MAX_NUMS+1) and SW = $clog2(LIVES+1).
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock, all state changes on its rising edge.
REQ-007 iReset  in  1  synchronous active-high reset.
REQ-008 iSpace  in  1  start key, level-sensitive.
REQ-009 iDoneLoad  in  1  board datapath has finished placing numbers.
REQ-010 iChoseCorrectNum  in  1  one-cycle pulse: player clicked the expected number.
REQ-011 iChoseWrongNum  in  1  one-cycle pulse: player clicked a wrong cell.
REQ-012 oNumToChoose  out  NW  number the player must click next; 0 outside CHOOSE.
REQ-013 oLevel  out  NW  current level (count of numbers on the board).
REQ-014 oStrikes  out  SW  wrong picks in the current game.
REQ-015 oBest  out  NW  highest level completed since reset.
REQ-016 oLoadEnable  out  1  request board datapath to place oLevel numbers.
REQ-017 oShowEnable  out  1  numbers visible on screen.
REQ-018 oResetBoard  out  1  clear the board.
REQ-019 oGameOver  out  1  game finished (lost or won).
REQ-020 oWin  out  1  game finished by completing level MAX_NUMS.
REQ-021 oState  out  3  state code: IDLE=0 ARM=1 LOAD=2 CHOOSE=3 NEXT=4 STRIKE=5 OVER=6.

Function
REQ-022 Level, number-to-choose, strikes, best and state SHALL all be registered; no combinational latches.
REQ-023 IDLE: level<=START_LEVEL, strikes<=0; iSpace=1 -> ARM.
REQ-024 ARM: waits for key release; iSpace=0 -> LOAD, else stay.
REQ-025 LOAD: oLoadEnable=1; iDoneLoad=1 -> CHOOSE with num<=1; else stay.
REQ-026 CHOOSE: iChoseWrongNum=1 -> STRIKE (wrong has priority over simultaneous correct).
REQ-027 CHOOSE: correct and num<level -> num<=num+1, stay; correct and num==level -> NEXT.
REQ-028 CHOOSE: no pulse -> hold num and state.
REQ-029 NEXT (one cycle): best<=max(best,level); level==MAX_NUMS -> OVER with win<=1; else level<=level+1 -> LOAD.
REQ-030 STRIKE (one cycle): strikes<=strikes+1; if strikes+1==LIVES -> OVER with win<=0; else -> LOAD at same level.
REQ-031 OVER: oGameOver=1, oWin=win; iSpace=1 -> ARM with level<=START_LEVEL, strikes<=0, win<=0; oBest retained.
REQ-032 Pick pulses outside CHOOSE SHALL be ignored; iDoneLoad outside LOAD SHALL be ignored.
REQ-033 oNumToChoose = num in CHOOSE, 0 in every other state.
REQ-034 oShowEnable=1 in LOAD, and in CHOOSE only while num==1 (numbers hide after first correct pick).
REQ-035 oResetBoard=1 in IDLE, ARM, STRIKE, NEXT, and whenever iReset=1.
REQ-036 oLevel SHALL never exceed MAX_NUMS nor fall below START_LEVEL; oStrikes never exceeds LIVES.
REQ-037 All outputs other than those in REQ-033..035 SHALL be driven directly from registers.

Reset
REQ-038 iReset=1 at a clock edge SHALL force state IDLE, level=START_LEVEL, num=0, strikes=0, best=0, win=0 from any state, including mid-CHOOSE and mid-LOAD.
REQ-039 Output values during reset/IDLE: oNumToChoose=0, oLevel=START_LEVEL, oStrikes=0, oBest=0, oLoadEnable=0, oShowEnable=0, oResetBoard=1, oGameOver=0, oWin=0, oState=0.

Verification (MAX_NUMS=5, START_LEVEL=2, LIVES=2)
REQ-040 Start: reset, iSpace 1 for 3 cycles then 0, iDoneLoad pulse -> oState 0->1->2->3, oNumToChoose=1, oShowEnable=1.
REQ-041 Level up: in CHOOSE level 2, correct, correct -> oShowEnable drops after first pulse, NEXT, oBest=2, oLevel=3, oState=2.
REQ-042 Strike: level 3, correct then wrong -> STRIKE, oStrikes=1, LOAD at oLevel=3; second wrong -> OVER, oGameOver=1, oWin=0.
REQ-043 Simultaneous correct+wrong in CHOOSE -> treated as wrong, oStrikes increments, num unchanged.
REQ-044 Win: complete levels 2..5 without errors -> OVER, oWin=1, oBest=5, oLevel=5; iSpace -> ARM, oLevel=2, oBest=5.
REQ-045 Reset mid-CHOOSE at level 4, num=3 -> next cycle oState=0, oLevel=2, oBest=0, oNumToChoose=0.
